fp_mantissa_normalizer: RTL and testbench
=========================================

// Module: fp_mantissa_normalizer
// PURPOSE
//  Post-add normalization stage of the floating-point adder datapath. Sits directly downstream of the
//  mantissa adder: accepts the raw 24-bit sum, its carry-out and the pre-normalization exponent.
//  Iteratively shifts to put the leading one at bit 23, adjusting the exponent. Reports zero, overflow
//  and underflow. One left shift per cycle; start/busy/done handshake to the adder control FSM.
// PARAMETERS
//  MANT_W   24     mantissa width incl. hidden bit
//  EXP_W    8      biased exponent width
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       request; sampled only in IDLE
//  sum_carry  in   1       carry-out of mantissa adder
//  sum_mant   in   MANT_W  raw mantissa sum
//  exp_in     in   EXP_W   exponent before normalization
//  busy       out  1       high from cycle after start accept until done cycle inclusive
//  done       out  1       one-cycle pulse; results valid
//  mant_out   out  MANT_W  normalized mantissa, held until next accepted start
//  exp_out    out  EXP_W   adjusted exponent, held likewise
//  zero       out  1       result is zero
//  overflow   out  1       exponent reached all-ones (inf)
//  underflow  out  1       could not normalize above EXP_MIN_NORM (denormal)
// BEHAVIOUR
//  - Reset (rst=1 at posedge, any state): state=IDLE; all outputs 0. Mid-op reset aborts, no done pulse.
//  - States: IDLE -> NORM -> ... -> NORM -> DONE -> IDLE.
//  - IDLE: on start, capture sum_carry/sum_mant/exp_in into working regs; clear zero/overflow/underflow;
//    go NORM. start while not IDLE is ignored (no queueing).
//  - NORM, evaluated each cycle in priority order:
//    1. carry=1: mant <= {1'b1, mant[23:1]}, exp <= exp+1; if exp+1 == all-ones: overflow=1, mant <= 0.
//       -> DONE
//    2. mant==0: zero=1, exp <= 0. -> DONE
//    3. mant[23]==1: already normal. -> DONE
//    4. exp <= EXP_MIN_NORM: underflow=1, exp <= 0, mant unchanged. -> DONE
//    5. else: mant <= {mant[22:0],1'b0}, exp <= exp-1; stay NORM.
//  - DONE: done=1 for exactly one cycle; mant_out/exp_out/flags driven from working regs. -> IDLE.
//  - Latency, start-sample edge to done-high cycle: 2 + L cycles, L = left shifts (0..23).
//    Max 25 cycles. Carry path always 2.
//  - Exponent arithmetic unsigned modulo 2^EXP_W; wrap cannot occur, guarded by rules 1 and 4.
//  - Outputs hold after DONE until the next accepted start clears flags (mant_out/exp_out update at DONE).
// STRUCTURE
//  - Shared package fp_pkg: MANT_W, EXP_W, EXP_ALL_ONES, EXP_MIN_NORM (=1), norm_state_t enum
//    {IDLE, NORM, DONE}.
//  - Sub-module: working mantissa held in the team's 24-bit left/right shift register block.
//    Load, and carry injection via parallel load, uses ld_mantice. Left shifts use shift_left.
//  - This module holds the FSM, exponent counter and flag regs.
// TESTING
//  1. sum_mant=0x400000, carry=0, exp_in=10 -> mant_out=0x800000, exp_out=9, flags 0;
//     done 3 cycles after start.
//  2. sum_mant=0x000001, carry=1, exp_in=0x80 -> mant_out=0x800000, exp_out=0x81; done at cycle 2.
//  3. sum_mant=0x000001, carry=0, exp_in=30 -> 23 shifts, mant_out=0x800000, exp_out=7;
//     done at cycle 25.
//  4. sum_mant=0, carry=0, exp_in=50 -> zero=1, exp_out=0, mant_out=0, done at 2;
//     then carry=1, exp_in=0xFE -> overflow=1, exp_out=0xFF, mant_out=0.
//  5. sum_mant=0x000100, exp_in=3 -> 2 shifts then underflow=1, exp_out=0, mant_out=0x000400;
//     done at 4.
//  6. Assert start repeatedly mid-NORM -> ignored, single done. Pulse rst at cycle 5 of case 3
//     -> outputs 0, no done; next start runs cleanly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point adder datapath.
// Mantissa widths include the hidden bit; exponents are biased and unsigned.
package fp_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MIN_NORM = EXP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } norm_state_t;

endpackage

// File: rtl/fp_mantissa_normalizer_shreg.sv
// 24-bit working mantissa register: parallel load, or a one-bit left/right shift per cycle.
// Load wins over shifts; shifted-in bits are zero.
module fp_mantissa_normalizer_shreg
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_mantice,
    input  logic [MANT_W-1:0] ld_data,
    input  logic              shift_left,
    input  logic              shift_right,
    output logic [MANT_W-1:0] mant_q
);

    logic [MANT_W-1:0] mant_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mant_d = mant_q;
        if (ld_mantice) begin
            mant_d = ld_data;
        end else if (shift_left) begin
            mant_d = {mant_q[MANT_W-2:0], 1'b0};
        end else if (shift_right) begin
            mant_d = {1'b0, mant_q[MANT_W-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments only; combinational logic uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            mant_q <= '0;
        end else begin
            mant_q <= mant_d;
        end
    end

endmodule

// File: rtl/fp_mantissa_normalizer.sv
// Post-add normalizer: one left shift per cycle until the leading one reaches the MSB,
// tracking the exponent and reporting zero / overflow / underflow with a start/busy/done handshake.
module fp_mantissa_normalizer
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sum_carry,
    input  logic [MANT_W-1:0] sum_mant,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              overflow,
    output logic              underflow
);

    norm_state_t       state_q, state_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              carry_q, carry_d;
    logic              zero_w_q, zero_w_d;
    logic              ovf_w_q, ovf_w_d;
    logic              unf_w_q, unf_w_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MANT_W-1:0] mant_out_q, mant_out_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic              zero_q, zero_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              mant_ld;
    logic [MANT_W-1:0] mant_ld_data;
    logic              mant_shl;
    logic [MANT_W-1:0] mant_w;
    logic [EXP_W-1:0]  exp_inc;

    fp_mantissa_normalizer_shreg u_shreg (
        .clk         (clk),
        .rst         (rst),
        .ld_mantice  (mant_ld),
        .ld_data     (mant_ld_data),
        .shift_left  (mant_shl),
        .shift_right (1'b0),
        .mant_q      (mant_w)
    );

    assign exp_inc = exp_q + EXP_W'(1);

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        carry_d      = carry_q;
        zero_w_d     = zero_w_q;
        ovf_w_d      = ovf_w_q;
        unf_w_d      = unf_w_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        mant_out_d   = mant_out_q;
        exp_out_d    = exp_out_q;
        zero_d       = zero_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        mant_ld      = 1'b0;
        mant_ld_data = '0;
        mant_shl     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mant_ld      = 1'b1;
                    mant_ld_data = sum_mant;
                    exp_d        = exp_in;
                    carry_d      = sum_carry;
                    zero_w_d     = 1'b0;
                    ovf_w_d      = 1'b0;
                    unf_w_d      = 1'b0;
                    zero_d       = 1'b0;
                    overflow_d   = 1'b0;
                    underflow_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = NORM;
                end
            end
            NORM: begin
                busy_d = 1'b1;
                if (carry_q) begin
                    // Carry-out: fold it back in as the new MSB with one right shift.
                    mant_ld = 1'b1;
                    exp_d   = exp_inc;
                    carry_d = 1'b0;
                    if (exp_inc == EXP_ALL_ONES) begin
                        ovf_w_d      = 1'b1;
                        mant_ld_data = '0;
                    end else begin
                        mant_ld_data = {1'b1, mant_w[MANT_W-1:1]};
                    end
                    state_d = DONE;
                end else if (mant_w == '0) begin
                    zero_w_d = 1'b1;
                    exp_d    = '0;
                    state_d  = DONE;
                end else if (mant_w[MANT_W-1]) begin
                    state_d = DONE;
                end else if (exp_q <= EXP_MIN_NORM) begin
                    unf_w_d = 1'b1;
                    exp_d   = '0;
                    state_d = DONE;
                end else begin
                    mant_shl = 1'b1;
                    exp_d    = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                busy_d      = 1'b1;
                done_d      = 1'b1;
                mant_out_d  = mant_w;
                exp_out_d   = exp_q;
                zero_d      = zero_w_q;
                overflow_d  = ovf_w_q;
                underflow_d = unf_w_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            carry_q     <= 1'b0;
            zero_w_q    <= 1'b0;
            ovf_w_q     <= 1'b0;
            unf_w_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mant_out_q  <= '0;
            exp_out_q   <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            carry_q     <= carry_d;
            zero_w_q    <= zero_w_d;
            ovf_w_q     <= ovf_w_d;
            unf_w_q     <= unf_w_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mant_out_q  <= mant_out_d;
            exp_out_q   <= exp_out_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mant_out  = mant_out_q;
    assign exp_out   = exp_out_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
// Scoreboard bench for fp_mantissa_normalizer: expected results are queued at launch
// and popped when done pulses; latency is counted in clock edges from the start-sample edge.
module tb_fp_mantissa_normalizer;
    import fp_pkg::*;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  expo;
        logic              zero;
        logic              ovf;
        logic              unf;
    } res_t;

    typedef struct {
        res_t res;
        int   lat;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              sum_carry = 1'b0;
    logic [MANT_W-1:0] sum_mant = '0;
    logic [EXP_W-1:0]  exp_in = '0;
    logic              busy, done, zero, overflow, underflow;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;

    int       checks = 0;
    int       failures = 0;
    sb_item_t sb_q[$];
    sb_item_t want;
    res_t     got;
    int       lat;
    bit       tmo;

    fp_mantissa_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sum_carry (sum_carry),
        .sum_mant  (sum_mant),
        .exp_in    (exp_in),
        .busy      (busy),
        .done      (done),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    function automatic sb_item_t mk(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                                    input logic z, input logic o, input logic u, input int l);
        sb_item_t x;
        x.res = {m, e, z, o, u};
        x.lat = l;
        return x;
    endfunction

    // Reference normalizer used for randomized operands.
    function automatic sb_item_t model(input logic c, input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e);
        sb_item_t x;
        logic [EXP_W-1:0] ei;
        x.res = '0;
        x.lat = 2;
        if (c) begin
            ei = e + 8'd1;
            x.res.expo = ei;
            if (ei == 8'hFF) begin
                x.res.ovf  = 1'b1;
                x.res.mant = '0;
            end else begin
                x.res.mant = {1'b1, m[MANT_W-1:1]};
            end
        end else begin
            for (int i = 0; i < 30; i++) begin
                if (m == '0) begin
                    x.res.zero = 1'b1;
                    e = '0;
                    break;
                end else if (m[MANT_W-1]) begin
                    break;
                end else if (e <= 8'd1) begin
                    x.res.unf = 1'b1;
                    e = '0;
                    break;
                end else begin
                    m = m << 1;
                    e = e - 8'd1;
                    x.lat++;
                end
            end
            x.res.mant = m;
            x.res.expo = e;
        end
        return x;
    endfunction

    task automatic launch(input logic c, input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                          input sb_item_t x);
        @(negedge clk);
        sum_carry = c;
        sum_mant  = m;
        exp_in    = e;
        start     = 1'b1;
        sb_q.push_back(x);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic await_done(output int l, output res_t r, output bit to);
        l  = 0;
        to = 1'b1;
        r  = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            l++;
            if (done) begin
                to = 1'b0;
                r  = {mant_out, exp_out, zero, overflow, underflow};
                break;
            end
        end
    endtask

    task automatic pop_want(output sb_item_t x);
        if (sb_q.size() > 0) x = sb_q.pop_front();
        else x = mk('1, '1, 1'b1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, mant_out, exp_out, zero, overflow, underflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {busy, done, mant_out, exp_out, zero, overflow, underflow});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_shift();
        launch(1'b0, 24'h400000, 8'd10, mk(24'h800000, 8'd9, 1'b0, 1'b0, 1'b0, 3));
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b required=1", busy); end
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res) begin failures++; $display("FAIL single_shift_result got=%h required=%h timeout=%0b", got, want.res, tmo); end
        checks++;
        if (lat !== want.lat) begin failures++; $display("FAIL single_shift_latency got=%0d required=%0d", lat, want.lat); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_done_cycle got=%b required=1", busy); end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00 || mant_out !== 24'h800000) begin
            failures++;
            $display("FAIL done_pulse_hold got done=%b busy=%b mant=%h required 0 0 800000", done, busy, mant_out);
        end
    endtask

    task automatic test_carry();
        launch(1'b1, 24'h000001, 8'h80, mk(24'h800000, 8'h81, 1'b0, 1'b0, 1'b0, 2));
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL carry got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
    endtask

    task automatic test_full_shift();
        launch(1'b0, 24'h000001, 8'd30, mk(24'h800000, 8'd7, 1'b0, 1'b0, 1'b0, 25));
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL full_shift got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
    endtask

    task automatic test_zero_overflow();
        launch(1'b0, 24'h000000, 8'd50, mk(24'h000000, 8'd0, 1'b1, 1'b0, 1'b0, 2));
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL zero got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
        launch(1'b1, 24'h000000, 8'hFE, mk(24'h000000, 8'hFF, 1'b0, 1'b1, 1'b0, 2));
        checks++;
        if ({zero, overflow, underflow} !== 3'b000) begin
            failures++;
            $display("FAIL flags_clear_on_start got=%b required=000", {zero, overflow, underflow});
        end
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL overflow got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
    endtask

    task automatic test_underflow();
        launch(1'b0, 24'h000100, 8'd3, mk(24'h000400, 8'd0, 1'b0, 1'b0, 1'b1, 4));
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL underflow got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        launch(1'b0, 24'h000001, 8'd30, mk(24'h800000, 8'd7, 1'b0, 1'b0, 1'b0, 25));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start     = 1'b1;
            sum_carry = 1'(i);
            sum_mant  = 24'h400000 >> i;
            exp_in    = 8'd100 + 8'(i);
        end
        @(negedge clk);
        start = 1'b0;
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat + 10 !== want.lat) begin
            failures++;
            $display("FAIL start_ignored got=%h lat=%0d required=%h lat=%0d", got, lat + 10, want.res, want.lat);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL start_ignored_single_done extra_dones=%0d required=0", extra); end
    endtask

    task automatic test_mid_reset();
        int seen;
        launch(1'b0, 24'h000001, 8'd30, mk(24'h800000, 8'd7, 1'b0, 1'b0, 1'b0, 25));
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({busy, done, mant_out, exp_out, zero, overflow, underflow} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h required=0",
                     {busy, done, mant_out, exp_out, zero, overflow, underflow});
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL mid_reset_no_done dones=%0d required=0", seen); end
        sb_q.delete();
        launch(1'b0, 24'h400000, 8'd10, mk(24'h800000, 8'd9, 1'b0, 1'b0, 1'b0, 3));
        await_done(lat, got, tmo);
        pop_want(want);
        checks++;
        if (tmo || got !== want.res || lat !== want.lat) begin
            failures++;
            $display("FAIL after_reset got=%h lat=%0d required=%h lat=%0d", got, lat, want.res, want.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic              c;
        logic [MANT_W-1:0] m;
        logic [EXP_W-1:0]  e;
        for (int i = 0; i < 12; i++) begin
            c = ($urandom_range(0, 3) == 0);
            m = MANT_W'($urandom() >> $urandom_range(8, 31));
            e = EXP_W'($urandom_range(0, 254));
            if (i == 0) begin c = 1'b1; e = 8'hFE; end
            launch(c, m, e, model(c, m, e));
            await_done(lat, got, tmo);
            pop_want(want);
            checks++;
            if (tmo || got !== want.res || lat !== want.lat) begin
                failures++;
                $display("FAIL b2b_%0d c=%b m=%h e=%h got=%h lat=%0d required=%h lat=%0d",
                         i, c, m, e, got, lat, want.res, want.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_shift();
        test_carry();
        test_full_shift();
        test_zero_overflow();
        test_underflow();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
